delay_calibrator: RTL and testbench
===================================

# delay_calibrator

Measures the acoustic round-trip delay, in audio samples, that `delay_audio` consumes on its `delay_length` input. On request it emits a short rectangular test pulse toward the speaker path. It then listens on the microphone stream and counts sample strobes until the echo magnitude crosses a threshold. The count is published as `delay_length`, or a timeout is flagged if no echo arrives within the delay buffer's capacity.

## Interface
Parameters:
- `MEMORY_SIZE`, 1000: depth of the downstream delay buffer; the largest reportable delay is `MEMORY_SIZE-1`.
- `PULSE_SAMPLES`, 4: number of strobes for which the pulse is driven.
- `PULSE_AMPLITUDE`, 16'sh4000: signed pulse level.
- `THRESHOLD`, 16'd2048: unsigned magnitude at or above which an echo is detected.
- `BLANK_SAMPLES`, 2: count values below this are never detected, which rejects direct leakage. Must be at least 1.

Ports:
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous and active-high.
- `audio_valid_in` input 1: one-cycle sample strobe, shared with `delay_audio`.
- `start_in` input 1: one-cycle calibration request.
- `mic_in` input 16: signed microphone sample, valid on strobe cycles.
- `test_audio_out` output 16: signed pulse/silence sample toward the speaker mix.
- `delay_length` output 16: last successful measurement.
- `delay_valid` output 1: level; `delay_length` holds a measurement from the most recent calibration.
- `done_out` output 1: one-cycle pulse when a calibration ends, whether by detection or timeout.
- `timeout_out` output 1: level; the most recent calibration found no echo.
- `busy_out` output 1: high in every state except IDLE.

## Operation
- States: IDLE, ARMED, EMIT, LISTEN.
- **IDLE**
  - `start_in` goes to ARMED.
  - It also clears `delay_valid` and `timeout_out`.
  - `start_in` is ignored in every other state.
- **ARMED**
  - Waits for the next strobe. That strobe is count 0: `test_audio_out <= PULSE_AMPLITUDE` and the state goes to EMIT.
  - A strobe arriving in the same cycle as `start_in` does not count; the pulse begins on the following strobe.
- **Counter**
  - 16-bit, unsigned.
  - On each strobe in EMIT or LISTEN, `mic_in` is evaluated against the current count `c`, then the counter increments.
- **EMIT**
  - `test_audio_out` holds `PULSE_AMPLITUDE` through count `PULSE_SAMPLES-1`.
  - On the strobe where `c == PULSE_SAMPLES-1`, `test_audio_out <= 0` at the next strobe and the state goes to LISTEN.
- **Detection** (evaluated in EMIT and LISTEN)
  - Condition: `|mic_in| >= THRESHOLD` and `c >= BLANK_SAMPLES`.
  - Magnitude is computed with saturation: |−32768| = 32767.
  - On detection: `delay_length <= c`, `delay_valid <= 1`, `done_out` pulses, `test_audio_out <= 0`, and the state goes to IDLE.
  - Detection takes priority over the EMIT→LISTEN transition and over timeout.
- **Timeout**
  - Triggered on the strobe where `c == MEMORY_SIZE-1` without detection.
  - Response: `timeout_out <= 1`, `done_out` pulses, the state goes to IDLE.
  - `delay_length` keeps its prior value and `delay_valid` stays 0.
- **Output limits**: `delay_length` is always in `[BLANK_SAMPLES, MEMORY_SIZE-1]`, so it is safe for `delay_audio`'s wrap arithmetic.
- **Between strobes**: all state holds; only strobe cycles advance the counter.

## Timing
- **Reset values**: state IDLE, counter 0, `test_audio_out` 0, `delay_length` 0, `delay_valid` 0, `done_out` 0, `timeout_out` 0, `busy_out` 0.
- **Reset mid-operation**: asynchronous return to IDLE with the reset values above.
- **Registered outputs**: all outputs change on the `clk_in` edge that samples the strobe, one cycle after `mic_in` is presented.
- **Status latency**: `done_out`, `delay_valid` and `timeout_out` assert in the cycle after the deciding strobe.
- **`busy_out` latency**: rises the cycle after `start_in`; falls in the same cycle that `done_out` is high.
- **Back-to-back**: a `start_in` in the cycle `done_out` is high is ignored; `start_in` is accepted from the next cycle.

## Structure
- Shared package `delay_cal_pkg` holds:
  - the state enum `cal_state_t`;
  - the default threshold and pulse constants;
  - a pure function `sat_abs16` computing the saturating magnitude.
- No sub-module: one FSM process, one counter, one output register block.
- Instantiated beside `delay_audio`, with `delay_length` wired directly to it.

## Test plan
- **Reset and idle**: assert `rst_in` mid-LISTEN → all outputs 0 and state IDLE immediately; strobes without `start_in` → `test_audio_out` stays 0.
- **Basic measure**: `start_in`, then model `mic_in` as `test_audio_out` delayed 37 strobes with gain 0.5 → `delay_length` = 37, `delay_valid` = 1, a single `done_out` pulse, `test_audio_out` = 16'h4000 for exactly 4 strobes.
- **Blanking**:
  - echo at count 1, repeated at count 50 → `delay_length` = 50;
  - echo at count 2 → `delay_length` = 2.
- **Threshold edge**:
  - |mic| = 2047 (including −2047) → no detection;
  - mic = −2048 → detected;
  - mic = −32768 → detected, no overflow.
- **Timeout**:
  - silent mic → `timeout_out` = 1 after 999 counted strobes, `delay_length` unchanged from a prior run of 37, `delay_valid` = 0;
  - echo at exactly count 999 → detected, not a timeout.
- **Handshake**:
  - `start_in` coincident with a strobe → pulse begins on the next strobe;
  - `start_in` while busy → ignored;
  - strobes spaced 1 and 2083 cycles apart → identical `delay_length`.

Source files
------------

// File: rtl/delay_cal_pkg.sv
// Shared types and constants for the acoustic round-trip delay calibrator.
// Holds the FSM state encoding, default pulse and threshold settings,
// and the saturating magnitude helper used by echo detection.
`timescale 1ns/1ps
package delay_cal_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        EMIT   = 2'd2,
        LISTEN = 2'd3
    } cal_state_t;

    localparam int                 DEF_MEMORY_SIZE     = 1000;
    localparam int                 DEF_PULSE_SAMPLES   = 4;
    localparam logic signed [15:0] DEF_PULSE_AMPLITUDE = 16'sh4000;
    localparam logic        [15:0] DEF_THRESHOLD       = 16'd2048;
    localparam int                 DEF_BLANK_SAMPLES   = 2;

    // |x| clamped to 32767 so the most negative sample cannot wrap back to itself.
    function automatic logic [15:0] sat_abs16(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7fff;
        end else if (x < 0) begin
            r = 16'(-x);
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_calibrator.sv
// Emits a short test pulse, then counts sample strobes until the mic echo crosses a threshold.
// Latency: all outputs registered; results appear the cycle after the deciding strobe.
// No backpressure: advances only on audio_valid_in strobes; start_in ignored while busy.
`timescale 1ns/1ps
module delay_calibrator
    import delay_cal_pkg::*;
#(
    parameter int                 MEMORY_SIZE     = DEF_MEMORY_SIZE,
    parameter int                 PULSE_SAMPLES   = DEF_PULSE_SAMPLES,
    parameter logic signed [15:0] PULSE_AMPLITUDE = DEF_PULSE_AMPLITUDE,
    parameter logic        [15:0] THRESHOLD       = DEF_THRESHOLD,
    parameter int                 BLANK_SAMPLES   = DEF_BLANK_SAMPLES
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               audio_valid_in,
    input  logic               start_in,
    input  logic signed [15:0] mic_in,
    output logic signed [15:0] test_audio_out,
    output logic        [15:0] delay_length,
    output logic               delay_valid,
    output logic               done_out,
    output logic               timeout_out,
    output logic               busy_out
);

    // Count values at which the pulse ends, the listen window closes, and blanking lifts.
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_SAMPLES - 1);
    localparam logic [15:0] COUNT_LAST = 16'(MEMORY_SIZE - 1);
    localparam logic [15:0] BLANK_CNT  = 16'(BLANK_SAMPLES);

    cal_state_t  state;
    logic [15:0] count;
    logic [15:0] mic_mag;
    logic        counting;
    logic        accept;
    logic        arm_fire;
    logic        detect;
    logic        expire;
    logic        pulse_end;

    // Per-cycle decisions; detection outranks timeout, which outranks the end of the pulse.
    always_comb begin
        mic_mag   = sat_abs16(mic_in);
        counting  = audio_valid_in && ((state == EMIT) || (state == LISTEN));
        // A start in the done cycle is dropped so the finishing result is seen for one clean cycle.
        accept    = (state == IDLE) && start_in && !done_out;
        arm_fire  = (state == ARMED) && audio_valid_in;
        detect    = counting && (mic_mag >= THRESHOLD) && (count >= BLANK_CNT);
        expire    = counting && !detect && (count == COUNT_LAST);
        pulse_end = counting && !detect && !expire && (state == EMIT) && (count == PULSE_LAST);
    end

    assign busy_out = (state != IDLE);

    // Calibration sequencing: IDLE -> ARMED -> EMIT -> LISTEN -> IDLE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)             state <= ARMED;
                ARMED:   if (arm_fire)           state <= EMIT;
                EMIT:    if (detect || expire)   state <= IDLE;
                         else if (pulse_end)     state <= LISTEN;
                LISTEN:  if (detect || expire)   state <= IDLE;
                default:                         state <= IDLE;
            endcase
        end
    end

    // Strobe counter: zeroed when a calibration is accepted, bumped on every counted strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (counting) begin
            count <= count + 16'd1;
        end
    end

    // Registered outputs: pulse level, measurement, and status flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            test_audio_out <= '0;
            delay_length   <= '0;
            delay_valid    <= 1'b0;
            done_out       <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            done_out <= detect || expire;
            if (accept) begin
                delay_valid <= 1'b0;
                timeout_out <= 1'b0;
            end
            if (arm_fire) begin
                test_audio_out <= PULSE_AMPLITUDE;
            end else if (detect || expire || pulse_end) begin
                test_audio_out <= '0;
            end
            if (detect) begin
                delay_length <= count;
                delay_valid  <= 1'b1;
            end
            if (expire) begin
                timeout_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_calibrator.sv
// Self-checking bench for delay_calibrator: table of calibration scenarios plus reset sequences.
// Expected results are queued when a calibration is started and popped when done_out fires.
// Stimulus is driven on the falling edge; DUT outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_delay_calibrator;

    localparam logic signed [15:0] PULSE = 16'sh4000;
    localparam int NONE = -100;

    logic               clk_in;
    logic               rst_in;
    logic               audio_valid_in;
    logic               start_in;
    logic signed [15:0] mic_in;
    logic signed [15:0] test_audio_out;
    logic        [15:0] delay_length;
    logic               delay_valid;
    logic               done_out;
    logic               timeout_out;
    logic               busy_out;

    delay_calibrator dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_valid_in (audio_valid_in),
        .start_in       (start_in),
        .mic_in         (mic_in),
        .test_audio_out (test_audio_out),
        .delay_length   (delay_length),
        .delay_valid    (delay_valid),
        .done_out       (done_out),
        .timeout_out    (timeout_out),
        .busy_out       (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_total   = 0;

    typedef struct {
        logic [15:0] len;
        logic        vld;
        logic        to;
    } res_t;

    typedef struct {
        int                 echo_a;
        logic signed [15:0] val_a;
        int                 echo_b;
        logic signed [15:0] val_b;
        int                 loop_d;
        int                 gap;
        bit                 coincide;
        int                 poke;
        bit                 b2b;
        int                 exp_pulses;
        logic        [15:0] exp_len;
        bit                 exp_vld;
        bit                 exp_to;
    } vec_t;

    res_t sb_q[$];
    vec_t vecs[$];

    always @(negedge clk_in) begin
        if (done_out === 1'b1) done_total <= done_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic vec_t mk(input int ea, input int va, input int eb, input int vb,
                                input int ld, input int gap, input bit co, input int poke,
                                input bit b2b, input int pul, input int len, input bit vld,
                                input bit to);
        vec_t v;
        v.echo_a = ea;  v.val_a = 16'(va);
        v.echo_b = eb;  v.val_b = 16'(vb);
        v.loop_d = ld;  v.gap = gap;  v.coincide = co;  v.poke = poke;  v.b2b = b2b;
        v.exp_pulses = pul;  v.exp_len = 16'(len);  v.exp_vld = vld;  v.exp_to = to;
        return v;
    endfunction

    // One full calibration: start, strobe stream with echo model, result check.
    task automatic run_vec(input int id, input vec_t v);
        logic signed [15:0] hist [0:1023];
        res_t exp;
        int   c;
        int   pulses;
        int   done_before;
        bit   finished;
        done_before = done_total;
        @(negedge clk_in);
        start_in       = 1'b1;
        audio_valid_in = v.coincide;
        mic_in         = '0;
        sb_q.push_back('{len: v.exp_len, vld: v.exp_vld, to: v.exp_to});
        @(negedge clk_in);
        start_in       = 1'b0;
        audio_valid_in = 1'b0;
        check($sformatf("v%0d busy_after_start", id), busy_out, 1);
        check($sformatf("v%0d valid_cleared", id), delay_valid, 0);
        check($sformatf("v%0d timeout_cleared", id), timeout_out, 0);
        repeat (v.gap - 1) @(negedge clk_in);
        c = -1;
        pulses = 0;
        finished = 1'b0;
        for (int s = 0; s < 1100 && !finished; s++) begin
            if (test_audio_out === PULSE) pulses++;
            if (c >= 0 && c < 1024) hist[c] = test_audio_out;
            mic_in = '0;
            if (v.loop_d > 0 && c >= v.loop_d) mic_in = hist[c - v.loop_d] >>> 1;
            if (c == v.echo_a) mic_in = v.val_a;
            if (c == v.echo_b) mic_in = v.val_b;
            start_in       = (c >= 0) && (c == v.poke);
            audio_valid_in = 1'b1;
            @(negedge clk_in);
            audio_valid_in = 1'b0;
            start_in       = 1'b0;
            mic_in         = '0;
            if (done_out === 1'b1) begin
                finished = 1'b1;
            end else begin
                c++;
                repeat (v.gap - 1) @(negedge clk_in);
            end
        end
        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL v%0d no_done: done_out absent after 1100 strobes, expected one pulse", id);
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            check($sformatf("v%0d delay_length", id), delay_length, exp.len);
            check($sformatf("v%0d delay_valid", id), delay_valid, exp.vld);
            check($sformatf("v%0d timeout_out", id), timeout_out, exp.to);
            check($sformatf("v%0d busy_at_done", id), busy_out, 0);
            check($sformatf("v%0d audio_silent_at_done", id), test_audio_out, 0);
            if (v.exp_pulses >= 0)
                check($sformatf("v%0d pulse_strobes", id), pulses, v.exp_pulses);
            if (v.b2b) start_in = 1'b1;
            @(negedge clk_in);
            start_in = 1'b0;
            check($sformatf("v%0d done_single_cycle", id), done_out, 0);
            check($sformatf("v%0d idle_after_done", id), busy_out, 0);
            check($sformatf("v%0d valid_held", id), delay_valid, exp.vld);
            check($sformatf("v%0d done_count", id), done_total - done_before, 1);
        end
    endtask

    initial begin
        int bad;
        rst_in         = 1'b1;
        start_in       = 1'b0;
        audio_valid_in = 1'b0;
        mic_in         = '0;

        //        ea    va      eb    vb      ld  gap   co poke  b2b pul len vld to
        vecs.push_back(mk(NONE, 0,      NONE, 0,      37, 2,    0, NONE, 0, 4,  37, 1, 0)); // loopback 37
        vecs.push_back(mk(NONE, 0,      NONE, 0,      0,  1,    0, NONE, 0, 4,  37, 0, 1)); // silent -> timeout
        vecs.push_back(mk(999,  16384,  NONE, 0,      0,  1,    0, NONE, 0, 4, 999, 1, 0)); // echo at last count
        vecs.push_back(mk(1,    8192,   50,   8192,   0,  1,    0, NONE, 0, 4,  50, 1, 0)); // blanked at 1
        vecs.push_back(mk(2,    8192,   NONE, 0,      0,  3,    0, NONE, 0, 3,   2, 1, 0)); // first unblanked
        vecs.push_back(mk(10,   2047,   20,   -2048,  0,  1,    0, NONE, 0, 4,  20, 1, 0)); // threshold edge
        vecs.push_back(mk(10,   -2047,  30,   -32768, 0,  2,    0, NONE, 0, 4,  30, 1, 0)); // -2047 / -32768
        vecs.push_back(mk(40,   2048,   NONE, 0,      0,  1,    0, NONE, 0, 4,  40, 1, 0)); // +2048 exact
        vecs.push_back(mk(3,    4096,   NONE, 0,      0,  1,    1, NONE, 0, 4,   3, 1, 0)); // start with strobe
        vecs.push_back(mk(12,   12288,  NONE, 0,      0,  2,    0, 5,    0, 4,  12, 1, 0)); // start while busy
        vecs.push_back(mk(10,   12288,  NONE, 0,      0,  1,    0, NONE, 1, 4,  10, 1, 0)); // start in done cycle
        vecs.push_back(mk(10,   12288,  NONE, 0,      0,  2083, 0, NONE, 0, 4,  10, 1, 0)); // sparse strobes
        vecs.push_back(mk(NONE, 0,      NONE, 0,      37, 1,    1, NONE, 0, 4,  37, 1, 0)); // loopback, coincident

        repeat (3) @(negedge clk_in);
        check("rst test_audio_out", test_audio_out, 0);
        check("rst delay_length", delay_length, 0);
        check("rst delay_valid", delay_valid, 0);
        check("rst done_out", done_out, 0);
        check("rst timeout_out", timeout_out, 0);
        check("rst busy_out", busy_out, 0);
        rst_in = 1'b0;

        bad = 0;
        for (int i = 0; i < 6; i++) begin
            audio_valid_in = 1'b1;
            mic_in = 16'sh4000;
            @(negedge clk_in);
            audio_valid_in = 1'b0;
            mic_in = '0;
            @(negedge clk_in);
            if (test_audio_out !== 16'sh0000 || busy_out !== 1'b0 || done_out !== 1'b0) bad++;
        end
        check("idle strobes without start", bad, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset deep into LISTEN must drop everything immediately, without a clock edge.
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            audio_valid_in = 1'b1;
            mic_in = '0;
            @(negedge clk_in);
            audio_valid_in = 1'b0;
        end
        check("listen busy before reset", busy_out, 1);
        #2 rst_in = 1'b1;
        #1;
        check("midrst busy_out", busy_out, 0);
        check("midrst delay_length", delay_length, 0);
        check("midrst delay_valid", delay_valid, 0);
        check("midrst timeout_out", timeout_out, 0);
        check("midrst done_out", done_out, 0);
        check("midrst test_audio_out", test_audio_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_vec(100, mk(7, -12288, NONE, 0, 0, 2, 0, NONE, 0, 4, 7, 1, 0));

        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d results left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
